// File: rtl/mc_sequencer.sv
// mc_sequencer: multicycle control FSM (IF/ID/EX/MEM/WB/ERR) for a one-hot-decoded ISA; strobes are Moore on state + latched decode.
// MEM stalls on mem_ready with a MEM_TIMEOUT bound; optional MC_SEQ_STEP_EN makes fetch fire only on a rising edge of run.
module mc_sequencer #(
  parameter int RSEL_W      = 2,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic [22:0]       opcode,
  input  logic [RSEL_W-1:0] rx,
  input  logic [RSEL_W-1:0] ry,
  input  logic [3:0]        flags,
  input  logic              mem_ready,
  output logic [2:0]        state,
  output logic              ir_we,
  output logic              pc_we,
  output logic              pc_src,
  output logic              rf_we,
  output logic              wb_src,
  output logic              alu_en,
  output logic              flags_we,
  output logic              dmem_re,
  output logic              dmem_we,
  output logic [RSEL_W-1:0] rf_wsel,
  output logic [RSEL_W-1:0] rf_rsel_a,
  output logic [RSEL_W-1:0] rf_rsel_b,
  output logic              mem_err,
  output logic              op_err,
  output logic [CNT_W-1:0]  retired
);

  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EX  = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;
  localparam logic [2:0] S_ERR = 3'd7;

  // Counter only has to reach MEM_TIMEOUT-1: the limit cycle decides ERR vs advance.
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  logic [2:0]        state_q;
  logic [2:0]        state_nxt;
  logic [22:0]       op_q;
  logic [RSEL_W-1:0] rx_q;
  logic [RSEL_W-1:0] ry_q;
  logic [WAIT_W-1:0] wait_q;
  logic [CNT_W-1:0]  retired_q;
  logic              mem_err_q;
  logic              op_err_q;
  logic              op_fail;
  logic              mem_fail;
  logic              retire;
  logic              fetch;

  logic flags_unused;
  assign flags_unused = ^flags[3:2];

`ifdef MC_SEQ_STEP_EN
  logic run_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run_q <= 1'b0;
    end else begin
      run_q <= run;
    end
  end

  assign fetch = run & ~run_q;
`else
  assign fetch = run;
`endif

  // Live decode, consulted only for the ID next-state decision.
  logic op_onehot;
  logic is_branch;
  logic br_taken;

  assign op_onehot = (opcode != '0) && ((opcode & (opcode - 23'd1)) == '0);
  assign is_branch = |opcode[22:19];
  assign br_taken  = (opcode[19] &  flags[0])
                   | (opcode[20] & ~flags[0])
                   | (opcode[21] & ~flags[0] & ~flags[1])
                   | (opcode[22] & ~flags[1]);

  // Latched decode classes drive every strobe after ID.
  logic c_noop;
  logic c_load;
  logic c_store;
  logic c_alu;
  logic c_cmp;
  logic c_flag;
  logic c_pcw;
  logic c_swap;

  assign c_noop  = op_q[0];
  assign c_load  = |{op_q[4:1], op_q[12:11]};
  assign c_store = |op_q[14:13];
  assign c_alu   = |{op_q[10:5], op_q[16:15]};
  assign c_cmp   = op_q[17];
  assign c_flag  = |{op_q[10:7], op_q[17:15]};
  assign c_pcw   = |op_q[22:18];
  assign c_swap  = op_q[5] | op_q[12] | op_q[13] | op_q[14];

  always_comb begin
    state_nxt = state_q;
    op_fail   = 1'b0;
    mem_fail  = 1'b0;
    case (state_q)
      S_IF: begin
        if (fetch) begin
          state_nxt = S_ID;
        end
      end
      S_ID: begin
        if (!op_onehot) begin
          state_nxt = S_ERR;
          op_fail   = 1'b1;
        end else if (opcode[0] || (is_branch && !br_taken)) begin
          state_nxt = S_IF;
        end else begin
          state_nxt = S_EX;
        end
      end
      S_EX: begin
        if (c_cmp || c_noop) begin
          state_nxt = S_IF;
        end else if (c_load || c_store) begin
          state_nxt = S_MEM;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          state_nxt = c_load ? S_WB : S_IF;
        end else if (wait_q == WAIT_LAST) begin
          state_nxt = S_ERR;
          mem_fail  = 1'b1;
        end
      end
      S_WB:    state_nxt = S_IF;
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_ERR;
    endcase
  end

  // Only ID/EX/MEM/WB can fall back to IF; ERR and unused codes never do.
  assign retire = (state_nxt == S_IF) && (state_q != S_IF);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IF;
      op_q      <= '0;
      rx_q      <= '0;
      ry_q      <= '0;
      wait_q    <= '0;
      retired_q <= '0;
      mem_err_q <= 1'b0;
      op_err_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      if (state_q == S_ID) begin
        op_q <= opcode;
        rx_q <= rx;
        ry_q <= ry;
      end
      if (state_q != S_MEM) begin
        wait_q <= '0;
      end else if (!mem_ready && (wait_q != WAIT_LAST)) begin
        wait_q <= wait_q + WAIT_W'(1);
      end
      if (retire && (retired_q != '1)) begin
        retired_q <= retired_q + CNT_W'(1);
      end
      mem_err_q <= mem_err_q | mem_fail;
      op_err_q  <= op_err_q | op_fail;
    end
  end

  always_comb begin
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_src   = 1'b0;
    rf_we    = 1'b0;
    wb_src   = 1'b0;
    alu_en   = 1'b0;
    flags_we = 1'b0;
    dmem_re  = 1'b0;
    dmem_we  = 1'b0;
    case (state_q)
      S_IF: begin
        ir_we = fetch;
        pc_we = fetch;
      end
      S_EX: begin
        alu_en   = 1'b1;
        flags_we = c_flag;
      end
      S_MEM: begin
        dmem_re = c_load;
        dmem_we = c_store;
      end
      S_WB: begin
        if (c_pcw) begin
          pc_we  = 1'b1;
          pc_src = 1'b1;
        end else if (c_load) begin
          rf_we  = 1'b1;
          wb_src = 1'b1;
        end else if (c_alu) begin
          rf_we = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  assign state     = state_q;
  assign rf_wsel   = rx_q;
  assign rf_rsel_a = c_swap ? ry_q : rx_q;
  assign rf_rsel_b = c_swap ? rx_q : ry_q;
  assign mem_err   = mem_err_q;
  assign op_err    = op_err_q;
  assign retired   = retired_q;

endmodule

// File: doc/mc_sequencer.md
MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 Parameter RSEL_W, default 2, register-select width (2^RSEL_W registers).
REQ-002 Parameter CNT_W, default 16, retired-instruction counter width.
REQ-003 Parameter MEM_TIMEOUT, default 15, max MEM cycles waiting on mem_ready.
REQ-004 Port list, one per line: name, direction, width, meaning.
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- run  in  1  fetch enable.
- opcode  in  23  one-hot class: bit0 NOOP, 1-4 INPUTC/INPUTCF/INPUTD/INPUTDF, 5 MOVE, 6 LOADI/LOADP, 7 ADD, 8 ADDI, 9 SUB, 10 SUBI, 11 LOAD, 12 LOADF, 13 STORE, 14 STOREF, 15 SHIFTL, 16 SHIFTR, 17 CMP, 18 JUMP, 19 BRE/BRZ, 20 BRNE/BRNZ, 21 BRG, 22 BRGE.
- rx, ry  in  RSEL_W  instruction register fields.
- flags  in  4  [0] Z, [1] N, [2] V, [3] C.
- mem_ready  in  1  data-memory access complete.
- state  out  3  current state code.
- ir_we, pc_we, pc_src, rf_we, wb_src, alu_en, flags_we, dmem_re, dmem_we  out  1 each  datapath strobes.
- rf_wsel, rf_rsel_a, rf_rsel_b  out  RSEL_W  register selects.
- mem_err, op_err  out  1  sticky error flags.
- retired  out  CNT_W  retired-instruction count.

Function
REQ-005 States: IF=0, ID=1, EX=2, MEM=3, WB=4, ERR=7; codes 5/6 unused and SHALL go to ERR.
REQ-006 IF: run=0 -> hold, all strobes 0; run=1 -> ir_we=1, pc_we=1, pc_src=0, next ID.
REQ-007 ID: opcode, rx, ry latched into internal registers; all later states use latched copies only.
REQ-008 ID: opcode not exactly one-hot -> ERR, op_err=1.
REQ-009 Paths: NOOP ID->IF; MOVE/LOADI/ADD/ADDI/SUB/SUBI/SHIFTL/SHIFTR ID->EX->WB->IF; CMP ID->EX->IF; LOAD/LOADF/INPUT* ID->EX->MEM->WB->IF; STORE/STOREF ID->EX->MEM->IF; JUMP ID->EX->WB->IF.
REQ-010 Branch taken tested in ID on live flags: BRE Z=1, BRNE Z=0, BRG Z=0&N=0, BRGE N=0; taken -> EX->WB->IF, else ID->IF.
REQ-011 Reads: MOVE/LOADF/STORE/STOREF: rf_rsel_a=ry, rf_rsel_b=rx; all others: a=rx, b=ry; rf_wsel=rx always.
REQ-012 EX: alu_en=1; flags_we=1 only for ADD/ADDI/SUB/SUBI/SHIFTL/SHIFTR/CMP.
REQ-013 MEM: dmem_re=1 (load class) or dmem_we=1 (store class), held until mem_ready=1 sampled, then advance next cycle.
REQ-014 MEM wait counter clears on MEM entry, increments each mem_ready=0 cycle; reaching MEM_TIMEOUT -> ERR, mem_err=1; mem_ready=1 on the limit cycle wins.
REQ-015 WB: ALU class rf_we=1, wb_src=0; load class rf_we=1, wb_src=1; JUMP/taken branch pc_we=1, pc_src=1, rf_we=0.
REQ-016 retired increments on each transition into IF from ID/EX/MEM/WB; saturates at all-ones.
REQ-017 ERR: all strobes 0, held until reset; retired frozen.
REQ-018 All strobes decoded from state plus latched decode only (Moore); no combinational path from opcode/flags to strobes except ID next-state.

Reset
REQ-019 reset=1 -> state IF, retired 0, mem_err/op_err 0, wait counter 0, latches 0, immediately, including mid-MEM.
REQ-020 First fetch on first rising clock after reset deasserts with run=1.

Configuration
REQ-021 Macro MC_SEQ_STEP_EN: defined -> IF leaves only on run rising edge (one instruction per edge, edge detector reset 0); undefined -> run is level-sensitive per REQ-006.

Verification
REQ-022 ADD, run=1, rx=2 -> IF,ID,EX,WB,IF; WB rf_we=1 rf_wsel=2; retired 0->1.
REQ-023 LOAD, mem_ready low 3 cycles -> MEM held 4 cycles with dmem_re=1, then WB wb_src=1.
REQ-024 STORE, mem_ready never high, MEM_TIMEOUT=15 -> ERR after 15 MEM cycles, mem_err=1, strobes 0.
REQ-025 BRG flags=0000 -> EX,WB pc_src=1; flags=0001 -> ID->IF, no pc_src.
REQ-026 opcode=0x000003 in ID -> ERR, op_err=1; reset -> IF, op_err=0.
REQ-027 With MC_SEQ_STEP_EN, run held high 20 cycles with NOOPs -> retired=1.
